// File: rtl/hist_eq_frame_ctrl_if.sv
// Control/status bundle between the frame sequencer and its host.
// The host side uses master, the sequencer uses slave.
interface hist_eq_frame_ctrl_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   i_start;
  logic                   i_continuous;
  logic                   i_bypass;
  logic                   i_abort;
  logic                   i_pixel_valid;
  logic                   o_rd_image;
  logic                   o_clear_hist;
  logic                   o_start_hist;
  logic                   o_start_mapping;
  logic                   o_map_bypass;
  logic                   o_done;
  logic                   o_busy;
  logic                   o_timeout;
  logic [2:0]             o_state;
  logic [FRAME_CNT_W-1:0] o_frame_count;

  modport master (
    output i_start, i_continuous, i_bypass, i_abort, i_pixel_valid,
    input  o_rd_image, o_clear_hist, o_start_hist, o_start_mapping, o_map_bypass,
    input  o_done, o_busy, o_timeout, o_state, o_frame_count
  );

  modport slave (
    input  i_start, i_continuous, i_bypass, i_abort, i_pixel_valid,
    output o_rd_image, o_clear_hist, o_start_hist, o_start_mapping, o_map_bypass,
    output o_done, o_busy, o_timeout, o_state, o_frame_count
  );
endinterface

// File: rtl/hist_eq_frame_ctrl.sv
// Histogram-equalisation frame sequencer: clear, accumulate, CDF wait, map; outputs registered (1 cycle).
// No backpressure: pixels are counted only when i_pixel_valid is high; a watchdog aborts stalled streams.
module hist_eq_frame_ctrl #(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int CDF_CYCLES     = 256,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  hist_eq_frame_ctrl_if.slave  bus
);

  localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W  = $clog2(PIXELS + 1);
  localparam int DLY_W  = $clog2(CDF_CYCLES + 1);
  localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(CDF_CYCLES - 1);
  localparam logic [TO_W-1:0]  WD_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_CDF   = 3'd3,
    S_MAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       pix_q, pix_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [TO_W-1:0]        wd_q, wd_d;
  logic                   byp_q, byp_d, cont_q, cont_d;
  logic                   rd_q, rd_d, clr_q, clr_d, sh_q, sh_d;
  logic                   sm_q, sm_d, mb_q, mb_d, done_q, done_d, to_q, to_d;
  logic [FRAME_CNT_W-1:0] fc_q, fc_d;
  logic                   wd_trip;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      dly_q   <= '0;
      wd_q    <= '0;
      byp_q   <= 1'b0;
      cont_q  <= 1'b0;
      rd_q    <= 1'b0;
      clr_q   <= 1'b0;
      sh_q    <= 1'b0;
      sm_q    <= 1'b0;
      mb_q    <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      dly_q   <= dly_d;
      wd_q    <= wd_d;
      byp_q   <= byp_d;
      cont_q  <= cont_d;
      rd_q    <= rd_d;
      clr_q   <= clr_d;
      sh_q    <= sh_d;
      sm_q    <= sm_d;
      mb_q    <= mb_d;
      done_q  <= done_d;
      to_q    <= to_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    dly_d   = dly_q;
    wd_d    = wd_q;
    byp_d   = byp_q;
    cont_d  = cont_q;
    rd_d    = rd_q;
    clr_d   = clr_q;
    sh_d    = sh_q;
    sm_d    = sm_q;
    mb_d    = mb_q;
    done_d  = done_q;
    to_d    = to_q;
    fc_d    = fc_q;
    wd_trip = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_CLEAR;
          clr_d   = 1'b1;
          to_d    = 1'b0;
          byp_d   = bus.i_bypass;
          cont_d  = bus.i_continuous;
        end
      end
      S_CLEAR: begin
        clr_d = 1'b0;
        rd_d  = 1'b1;
        if (byp_q) begin
          state_d = S_MAP;
          mb_d    = 1'b1;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.i_pixel_valid) begin
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            rd_d    = 1'b0;
            sh_d    = 1'b1;
            state_d = S_CDF;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      S_CDF: begin
        sh_d = 1'b0;
        if (dly_q == DLY_LAST) begin
          dly_d   = '0;
          sm_d    = 1'b1;
          rd_d    = 1'b1;
          state_d = S_MAP;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      S_MAP: begin
        if (bus.i_pixel_valid) begin
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            rd_d    = 1'b0;
            sm_d    = 1'b0;
            mb_d    = 1'b0;
            done_d  = 1'b1;
            fc_d    = fc_q + 1'b1;
            state_d = S_DONE;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!bus.i_start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cont_q) begin
          done_d  = 1'b0;
          clr_d   = 1'b1;
          byp_d   = bus.i_bypass;
          cont_d  = bus.i_continuous;
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stall watchdog: only streaming states count, a valid pixel restarts it.
    if (TIMEOUT_CYCLES > 0 && (state_q == S_ACCUM || state_q == S_MAP)) begin
      if (bus.i_pixel_valid) begin
        wd_d = '0;
      end else if (wd_q == WD_LAST) begin
        wd_trip = 1'b1;
        to_d    = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end

    // Abort overrides every transition above, including the frame-count bump.
    if (state_q != S_IDLE && (bus.i_abort || wd_trip)) begin
      state_d = S_IDLE;
      pix_d   = '0;
      dly_d   = '0;
      wd_d    = '0;
      rd_d    = 1'b0;
      clr_d   = 1'b0;
      sh_d    = 1'b0;
      sm_d    = 1'b0;
      mb_d    = 1'b0;
      done_d  = 1'b0;
      fc_d    = fc_q;
    end
  end

  assign bus.o_rd_image      = rd_q;
  assign bus.o_clear_hist    = clr_q;
  assign bus.o_start_hist    = sh_q;
  assign bus.o_start_mapping = sm_q;
  assign bus.o_map_bypass    = mb_q;
  assign bus.o_done          = done_q;
  assign bus.o_timeout       = to_q;
  assign bus.o_frame_count   = fc_q;
  assign bus.o_busy          = (state_q != S_IDLE);
  assign bus.o_state         = state_q;

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Directed bench for hist_eq_frame_ctrl with an 8-pixel frame, 4-cycle CDF and 16-cycle watchdog.
// Outputs are sampled 1 time unit after each rising edge.
module tb_hist_eq_frame_ctrl;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [10:0] obs, want;

  hist_eq_frame_ctrl_if #(.FRAME_CNT_W(16)) bus ();

  hist_eq_frame_ctrl #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .CDF_CYCLES(4), .TIMEOUT_CYCLES(16), .FRAME_CNT_W(16)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  assign obs = {bus.o_state, bus.o_rd_image, bus.o_clear_hist, bus.o_start_hist,
                bus.o_start_mapping, bus.o_map_bypass, bus.o_done, bus.o_busy, bus.o_timeout};

  function automatic logic [10:0] ev(input logic [2:0] s, input logic rd, input logic clr,
                                     input logic sh, input logic sm, input logic mb,
                                     input logic dn, input logic to);
    return {s, rd, clr, sh, sm, mb, dn, (s != 3'd0), to};
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    bus.i_start = 0; bus.i_continuous = 0; bus.i_bypass = 0;
    bus.i_abort = 0; bus.i_pixel_valid = 0;
    i_reset = 1;
    tick; tick;
    i_reset = 0;
  endtask

  task automatic test_reset;
    do_reset;
    i_reset = 1;
    tick;
    want = ev(0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, want); end
    checks++;
    if (bus.o_frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.o_frame_count); end
    checks++;
    i_reset = 0;
  endtask

  task automatic test_single_frame;
    do_reset;
    bus.i_start = 1; bus.i_pixel_valid = 1;
    tick;
    want = ev(1, 0, 1, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t1_clear: got %b want %b", obs, want); end
    checks++;
    tick;
    want = ev(2, 1, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t1_accum_entry: got %b want %b", obs, want); end
    checks++;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (obs !== want) begin errors++; $display("FAIL t1_accum[%0d]: got %b want %b", i, obs, want); end
      checks++;
    end
    tick;
    want = ev(3, 0, 0, 1, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t1_start_hist: got %b want %b", obs, want); end
    checks++;
    want = ev(3, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      if (obs !== want) begin errors++; $display("FAIL t1_cdf[%0d]: got %b want %b", i, obs, want); end
      checks++;
    end
    want = ev(4, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (obs !== want) begin errors++; $display("FAIL t1_map[%0d]: got %b want %b", i, obs, want); end
      checks++;
    end
    want = ev(5, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      if (obs !== want) begin errors++; $display("FAIL t1_done[%0d]: got %b want %b", i, obs, want); end
      checks++;
    end
    if (bus.o_frame_count !== 16'd1) begin errors++; $display("FAIL t1_count: got %0d want 1", bus.o_frame_count); end
    checks++;
    bus.i_start = 0;
    tick;
    want = ev(0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t1_idle: got %b want %b", obs, want); end
    checks++;
  endtask

  task automatic test_sparse_valid;
    do_reset;
    bus.i_start = 1;
    tick; tick;
    for (int p = 0; p < 8; p++) begin
      bus.i_pixel_valid = 0; tick; tick;
      bus.i_pixel_valid = 1; tick;
      want = (p < 7) ? ev(2, 1, 0, 0, 0, 0, 0, 0) : ev(3, 0, 0, 1, 0, 0, 0, 0);
      if (obs !== want) begin errors++; $display("FAIL t2_accum[%0d]: got %b want %b", p, obs, want); end
      checks++;
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      want = (i < 3) ? ev(3, 0, 0, 0, 0, 0, 0, 0) : ev(4, 1, 0, 0, 1, 0, 0, 0);
      if (obs !== want) begin errors++; $display("FAIL t2_cdf[%0d]: got %b want %b", i, obs, want); end
      checks++;
    end
    for (int p = 0; p < 8; p++) begin
      bus.i_pixel_valid = 0; tick; tick;
      bus.i_pixel_valid = 1; tick;
      want = (p < 7) ? ev(4, 1, 0, 0, 1, 0, 0, 0) : ev(5, 0, 0, 0, 0, 0, 1, 0);
      if (obs !== want) begin errors++; $display("FAIL t2_map[%0d]: got %b want %b", p, obs, want); end
      checks++;
    end
    if (bus.o_frame_count !== 16'd1) begin errors++; $display("FAIL t2_count: got %0d want 1", bus.o_frame_count); end
    checks++;
    bus.i_start = 0; bus.i_pixel_valid = 0;
    tick;
  endtask

  task automatic test_continuous;
    do_reset;
    bus.i_start = 1; bus.i_continuous = 1; bus.i_pixel_valid = 1;
    for (int f = 0; f < 3; f++) begin
      tick;
      want = ev(1, 0, 1, 0, 0, 0, 0, 0);
      if (obs !== want) begin errors++; $display("FAIL t3_clear[%0d]: got %b want %b", f, obs, want); end
      checks++;
      for (int k = 0; k < 21; k++) begin
        tick;
        if (f == 2 && k == 4) bus.i_start = 0;
      end
      want = ev(5, 0, 0, 0, 0, 0, 1, 0);
      if (obs !== want) begin errors++; $display("FAIL t3_done[%0d]: got %b want %b", f, obs, want); end
      checks++;
      if (bus.o_frame_count !== 16'(f + 1)) begin
        errors++; $display("FAIL t3_count[%0d]: got %0d want %0d", f, bus.o_frame_count, f + 1);
      end
      checks++;
    end
    tick;
    want = ev(0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t3_idle: got %b want %b", obs, want); end
    checks++;
    bus.i_continuous = 0;
  endtask

  task automatic test_bypass;
    do_reset;
    bus.i_bypass = 1; bus.i_start = 1; bus.i_pixel_valid = 1;
    tick;
    bus.i_bypass = 0;
    want = ev(4, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (obs !== want) begin errors++; $display("FAIL t4_map[%0d]: got %b want %b", i, obs, want); end
      checks++;
    end
    tick;
    want = ev(5, 0, 0, 0, 0, 0, 1, 0);
    if (obs !== want) begin errors++; $display("FAIL t4_done: got %b want %b", obs, want); end
    checks++;
    if (bus.o_frame_count !== 16'd1) begin errors++; $display("FAIL t4_count: got %0d want 1", bus.o_frame_count); end
    checks++;
    bus.i_start = 0;
    tick;
  endtask

  task automatic test_abort;
    bus.i_start = 1; bus.i_pixel_valid = 1;
    for (int i = 0; i < 11; i++) tick;
    want = ev(3, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t5_cdf2: got %b want %b", obs, want); end
    checks++;
    bus.i_abort = 1; bus.i_start = 0;
    tick;
    want = ev(0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t5_abort_cdf: got %b want %b", obs, want); end
    checks++;
    if (bus.o_frame_count !== 16'd1) begin errors++; $display("FAIL t5_count_cdf: got %0d want 1", bus.o_frame_count); end
    checks++;
    bus.i_abort = 0; bus.i_start = 1;
    for (int i = 0; i < 21; i++) tick;
    want = ev(4, 1, 0, 0, 1, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t5_map7: got %b want %b", obs, want); end
    checks++;
    bus.i_abort = 1; bus.i_start = 0;
    tick;
    want = ev(0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t5_abort_last: got %b want %b", obs, want); end
    checks++;
    if (bus.o_frame_count !== 16'd1) begin errors++; $display("FAIL t5_count_last: got %0d want 1", bus.o_frame_count); end
    checks++;
    tick;
    if (obs !== want) begin errors++; $display("FAIL t5_abort_idle: got %b want %b", obs, want); end
    checks++;
    bus.i_abort = 0; bus.i_start = 1;
    for (int i = 0; i < 22; i++) tick;
    want = ev(5, 0, 0, 0, 0, 0, 1, 0);
    if (obs !== want) begin errors++; $display("FAIL t5_recover: got %b want %b", obs, want); end
    checks++;
    if (bus.o_frame_count !== 16'd2) begin errors++; $display("FAIL t5_count_recover: got %0d want 2", bus.o_frame_count); end
    checks++;
    bus.i_start = 0;
    tick;
  endtask

  task automatic test_watchdog;
    do_reset;
    bus.i_start = 1; bus.i_pixel_valid = 1;
    tick; tick; tick; tick; tick;
    bus.i_pixel_valid = 0;
    want = ev(2, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      tick;
      if (obs !== want) begin errors++; $display("FAIL t6_stall[%0d]: got %b want %b", i, obs, want); end
      checks++;
    end
    tick;
    want = ev(0, 0, 0, 0, 0, 0, 0, 1);
    if (obs !== want) begin errors++; $display("FAIL t6_timeout: got %b want %b", obs, want); end
    checks++;
    tick;
    want = ev(1, 0, 1, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t6_restart: got %b want %b", obs, want); end
    checks++;
    bus.i_pixel_valid = 1;
    for (int i = 0; i < 21; i++) tick;
    want = ev(5, 0, 0, 0, 0, 0, 1, 0);
    if (obs !== want) begin errors++; $display("FAIL t6_done: got %b want %b", obs, want); end
    checks++;
    if (bus.o_frame_count !== 16'd1) begin errors++; $display("FAIL t6_count: got %0d want 1", bus.o_frame_count); end
    checks++;
    bus.i_start = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    bus.i_start = 1; bus.i_pixel_valid = 1;
    tick; tick; tick;
    i_reset = 1;
    tick;
    want = ev(0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== want) begin errors++; $display("FAIL t7_reset_mid: got %b want %b", obs, want); end
    checks++;
    if (bus.o_frame_count !== 16'd0) begin errors++; $display("FAIL t7_reset_count: got %0d want 0", bus.o_frame_count); end
    checks++;
    i_reset = 0; bus.i_start = 0; bus.i_pixel_valid = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_sparse_valid;
    test_continuous;
    test_bypass;
    test_abort;
    test_watchdog;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
